// File: rtl/fpu_realt_scoreboard.sv
// fpu_realt_scoreboard
// Scoreboard for N_CH-channel real_t (IEEE-754 single) results. Expected
// transactions from the model are queued in a FIFO. Each RTL transaction is
// compared against the FIFO head, or directly against the incoming expected
// word when the FIFO is empty. Pass and fail counts are accumulated, and the
// first failure is recorded.
//
// Optional feature macro: FPU_SCB_ULP_TOL_EN. When it is defined, non-NaN
// channels with equal sign also match when their 31-bit magnitude encodings
// differ by no more than ULP_TOL.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   i_exp_valid, i_exp  expected transaction push
//   o_exp_ready         FIFO not full
//   i_act_valid, i_act  RTL result transaction to compare
//   o_level             FIFO occupancy, 0..DEPTH
//   o_pass_cnt/o_fail_cnt  saturating compare counters
//   o_err               sticky: any fail, overflow or underflow
//   o_overflow/o_underflow sticky protocol-error flags
//   o_first_fail_idx/o_first_fail_mask  index and channel mask of first fail
module fpu_realt_scoreboard #(
   parameter int unsigned N_CH    = 2,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ULP_TOL = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_exp_valid,
   input  logic [N_CH-1:0][31:0]        i_exp,
   output logic                         o_exp_ready,
   input  logic                         i_act_valid,
   input  logic [N_CH-1:0][31:0]        i_act,
   output logic [$clog2(DEPTH):0]       o_level,
   output logic [31:0]                  o_pass_cnt,
   output logic [31:0]                  o_fail_cnt,
   output logic                         o_err,
   output logic                         o_overflow,
   output logic                         o_underflow,
   output logic [31:0]                  o_first_fail_idx,
   output logic [N_CH-1:0]              o_first_fail_mask
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   // Elaboration-time parameter sanity check
   if (N_CH < 1 || N_CH > 8 || DEPTH < 2 || DEPTH > 256 ||
       (DEPTH & (DEPTH - 1)) != 0 || ULP_TOL > 32'h7FFF_FFFF) begin : g_bad_param
      $error("fpu_realt_scoreboard: parameter out of range");
   end

   logic [N_CH-1:0][31:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [31:0]           txn_idx;

   logic                  empty, full;
   logic                  pop, bypass, under, push, ovf, cmp_valid, cmp_fail;
   logic [N_CH-1:0][31:0] ref_data;
   logic [N_CH-1:0]       fail_mask;
   logic [LW-1:0]         level_nxt;

   // Per-channel match: bit-equal, both NaN, or both zero of either sign
   function automatic logic ch_match(input logic [31:0] a, input logic [31:0] b);
      logic a_nan, b_nan, m;
`ifdef FPU_SCB_ULP_TOL_EN
      logic [30:0] diff;
`endif
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      m = (a == b) || (a_nan && b_nan) || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
`ifdef FPU_SCB_ULP_TOL_EN
      diff = (a[30:0] >= b[30:0]) ? (a[30:0] - b[30:0]) : (b[30:0] - a[30:0]);
      if (!a_nan && !b_nan && (a[31] == b[31]) && (diff <= 31'(ULP_TOL)))
         m = 1'b1;
`endif
      return m;
   endfunction

   assign empty = (o_level == LW'(0));
   assign full  = (o_level == LW'(DEPTH));

   // A push while full is still accepted when the same cycle pops, so
   // simultaneous push/pop on a full FIFO keeps the level at DEPTH.
   always_comb begin
      pop       = i_act_valid && !empty;
      bypass    = i_act_valid && empty && i_exp_valid;
      under     = i_act_valid && empty && !i_exp_valid;
      push      = i_exp_valid && !bypass && (!full || pop);
      ovf       = i_exp_valid && full && !pop;
      cmp_valid = pop || bypass;
      ref_data  = pop ? mem[rd_ptr] : i_exp;
      for (int c = 0; c < int'(N_CH); c++) begin
         fail_mask[c] = !ch_match(ref_data[c], i_act[c]);
      end
      cmp_fail  = |fail_mask;
      level_nxt = o_level;
      if (push && !pop)
         level_nxt = o_level + LW'(1);
      else if (pop && !push)
         level_nxt = o_level - LW'(1);
   end

   // Expected-data storage; contents need no reset
   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr] <= i_exp;
   end

   // Pointers, occupancy, counters and sticky status
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         o_level           <= '0;
         o_exp_ready       <= 1'b1;
         txn_idx           <= '0;
         o_pass_cnt        <= '0;
         o_fail_cnt        <= '0;
         o_err             <= 1'b0;
         o_overflow        <= 1'b0;
         o_underflow       <= 1'b0;
         o_first_fail_idx  <= '0;
         o_first_fail_mask <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         o_level     <= level_nxt;
         o_exp_ready <= (level_nxt != LW'(DEPTH));
         if (ovf)   o_overflow  <= 1'b1;
         if (under) o_underflow <= 1'b1;
         if (ovf || under || (cmp_valid && cmp_fail)) o_err <= 1'b1;
         if (cmp_valid) begin
            txn_idx <= txn_idx + 32'd1;
            if (cmp_fail) begin
               if (o_fail_cnt != '1) o_fail_cnt <= o_fail_cnt + 32'd1;
               // Fail count never returns to zero (saturates), so zero means first fail
               if (o_fail_cnt == 32'd0) begin
                  o_first_fail_idx  <= txn_idx;
                  o_first_fail_mask <= fail_mask;
               end
            end else if (o_pass_cnt != '1) begin
               o_pass_cnt <= o_pass_cnt + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpu_realt_scoreboard.sv
// Self-checking bench for fpu_realt_scoreboard (default build, N_CH=2, DEPTH=16).
module tb_fpu_realt_scoreboard;

   localparam int unsigned N_CH  = 2;
   localparam int unsigned DEPTH = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  i_exp_valid;
   logic [N_CH-1:0][31:0] i_exp;
   logic                  o_exp_ready;
   logic                  i_act_valid;
   logic [N_CH-1:0][31:0] i_act;
   logic [4:0]            o_level;
   logic [31:0]           o_pass_cnt, o_fail_cnt;
   logic                  o_err, o_overflow, o_underflow;
   logic [31:0]           o_first_fail_idx;
   logic [N_CH-1:0]       o_first_fail_mask;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fpu_realt_scoreboard #(.N_CH(N_CH), .DEPTH(DEPTH), .ULP_TOL(1)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_exp_valid       (i_exp_valid),
      .i_exp             (i_exp),
      .o_exp_ready       (o_exp_ready),
      .i_act_valid       (i_act_valid),
      .i_act             (i_act),
      .o_level           (o_level),
      .o_pass_cnt        (o_pass_cnt),
      .o_fail_cnt        (o_fail_cnt),
      .o_err             (o_err),
      .o_overflow        (o_overflow),
      .o_underflow       (o_underflow),
      .o_first_fail_idx  (o_first_fail_idx),
      .o_first_fail_mask (o_first_fail_mask)
   );

   typedef struct {
      logic        ev;
      logic [63:0] e;
      logic        av;
      logic [63:0] a;
      int          lvl;
      int          pass;
      int          fail;
      logic        err;
      int          ffi;
      int          ffm;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Apply inputs for one clock edge, then sample 1ns after the edge
   task automatic step(input logic ev, input logic [63:0] e, input logic av, input logic [63:0] a);
      i_exp_valid = ev;
      i_exp       = e;
      i_act_valid = av;
      i_act       = a;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 64'd0, 1'b0, 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;
   endtask

   function automatic logic [63:0] fill_word(input int i);
      return {32'h4100_0000 + 32'(i), 32'h4000_0000 + 32'(i)};
   endfunction

   task automatic fill_fifo();
      for (int i = 0; i < int'(DEPTH); i++) step(1'b1, fill_word(i), 1'b0, 64'd0);
   endtask

   task automatic chk_status(input string tag, input int lvl, input int pass, input int fail,
                             input logic err, input logic ovf, input logic und, input logic rdy);
      chk({tag, ".level"}, 32'(o_level), 32'(lvl));
      chk({tag, ".pass"}, o_pass_cnt, 32'(pass));
      chk({tag, ".fail"}, o_fail_cnt, 32'(fail));
      chk({tag, ".err"}, 32'(o_err), 32'(err));
      chk({tag, ".ovf"}, 32'(o_overflow), 32'(ovf));
      chk({tag, ".und"}, 32'(o_underflow), 32'(und));
      chk({tag, ".ready"}, 32'(o_exp_ready), 32'(rdy));
   endtask

   initial begin
      // ch1 in the upper word, ch0 in the lower word
      vecs[0]  = '{1'b1, 64'h4000_0000_3F80_0000, 1'b0, 64'd0, 1, 0, 0, 1'b0, 0, 0};
      vecs[1]  = '{1'b1, 64'h4080_0000_4040_0000, 1'b0, 64'd0, 2, 0, 0, 1'b0, 0, 0};
      vecs[2]  = '{1'b1, 64'h40C0_0000_40A0_0000, 1'b0, 64'd0, 3, 0, 0, 1'b0, 0, 0};
      vecs[3]  = '{1'b0, 64'd0, 1'b1, 64'h4000_0000_3F80_0000, 2, 1, 0, 1'b0, 0, 0};
      vecs[4]  = '{1'b0, 64'd0, 1'b1, 64'h4080_0000_4040_0000, 1, 2, 0, 1'b0, 0, 0};
      vecs[5]  = '{1'b0, 64'd0, 1'b1, 64'h40C0_0000_40A0_0000, 0, 3, 0, 1'b0, 0, 0};
      vecs[6]  = '{1'b1, 64'h4100_0000_40E0_0000, 1'b1, 64'h4100_0000_40E0_0000, 0, 4, 0, 1'b0, 0, 0};
      vecs[7]  = '{1'b1, 64'h3F80_0000_3F80_0000, 1'b1, 64'h3F80_0002_3F80_0000, 0, 4, 1, 1'b1, 4, 2};
      vecs[8]  = '{1'b1, 64'h0000_0000_7FC0_0000, 1'b0, 64'd0, 1, 4, 1, 1'b1, 4, 2};
      vecs[9]  = '{1'b0, 64'd0, 1'b1, 64'h8000_0000_7F80_0001, 0, 5, 1, 1'b1, 4, 2};
      vecs[10] = '{1'b1, 64'h3F80_0000_7F80_0000, 1'b1, 64'h3F80_0000_7FC0_0000, 0, 5, 2, 1'b1, 4, 2};
      vecs[11] = '{1'b0, 64'd0, 1'b0, 64'd0, 0, 5, 2, 1'b1, 4, 2};

      rst = 1'b1;
      i_exp_valid = 1'b0;
      i_exp = '0;
      i_act_valid = 1'b0;
      i_act = '0;
      do_reset();

      // Reset state
      chk_status("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset.ffi", o_first_fail_idx, 32'd0);
      chk("reset.ffm", 32'(o_first_fail_mask), 32'd0);

      // Streaming pass/fail, NaN/zero equivalence and first-fail capture
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].ev, vecs[i].e, vecs[i].av, vecs[i].a);
         chk_status($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].pass, vecs[i].fail,
                    vecs[i].err, 1'b0, 1'b0, 1'b1);
         chk($sformatf("vec%0d.ffi", i), o_first_fail_idx, 32'(vecs[i].ffi));
         chk($sformatf("vec%0d.ffm", i), 32'(o_first_fail_mask), 32'(vecs[i].ffm));
      end

      // Overflow: full FIFO drops an extra push and keeps its contents intact
      do_reset();
      fill_fifo();
      chk_status("full", 16, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 64'd0);
      chk_status("ovf", 16, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 64'd0, 1'b1, fill_word(i));
      chk_status("ovf_drain", 0, 16, 0, 1'b1, 1'b1, 1'b0, 1'b1);

      // Underflow: actual with empty FIFO and no push
      do_reset();
      step(1'b0, 64'd0, 1'b1, 64'h3F80_0000_3F80_0000);
      chk_status("und", 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1);

      // Bypass on empty FIFO, then push+pop on a full FIFO
      do_reset();
      step(1'b1, 64'h4040_0000_4000_0000, 1'b1, 64'h4040_0000_4000_0000);
      chk_status("bypass", 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      fill_fifo();
      step(1'b1, 64'h4200_0000_4200_0000, 1'b1, fill_word(0));
      chk("full_pp.level", 32'(o_level), 32'd16);
      chk("full_pp.pass", o_pass_cnt, 32'd2);
      chk("full_pp.fail", o_fail_cnt, 32'd0);
      for (int i = 1; i < int'(DEPTH); i++) step(1'b0, 64'd0, 1'b1, fill_word(i));
      step(1'b0, 64'd0, 1'b1, 64'h4200_0000_4200_0000);
      chk("full_pp_drain.level", 32'(o_level), 32'd0);
      chk("full_pp_drain.pass", o_pass_cnt, 32'd18);
      chk("full_pp_drain.fail", o_fail_cnt, 32'd0);

      // Mid-stream reset discards queued work; inputs ignored during reset
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, fill_word(i), 1'b0, 64'd0);
      step(1'b0, 64'd0, 1'b1, 64'h0);
      chk("pre_rst.fail", o_fail_cnt, 32'd1);
      chk("pre_rst.level", 32'(o_level), 32'd4);
      rst = 1'b1;
      step(1'b1, fill_word(7), 1'b1, fill_word(9));
      rst = 1'b0;
      chk_status("mid_rst", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("mid_rst.ffi", o_first_fail_idx, 32'd0);
      chk("mid_rst.ffm", 32'(o_first_fail_mask), 32'd0);
      idle();
      chk_status("post_rst", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
